sn74ls245_busctl: RTL

//  Sequencer for the A side of an sn74ls245 bidirectional transceiver.

---
 rtl/sn74ls245_busctl_if.sv | 26 ++
 rtl/sn74ls245_busctl.sv | 126 ++++++++++++
 2 files changed

// File: rtl/sn74ls245_busctl_if.sv
// Bus bundle between the local master / '245 A-side pads and the sn74ls245_busctl sequencer.
// The A-side tristate is split into a_o/a_oe/a_i; the pad ring builds a = a_oe ? a_o : 'z.
interface sn74ls245_busctl_if;
  logic       req;
  logic       we;
  logic [7:0] wdata;
  logic       rdy;
  logic       ack;
  logic       err;
  logic [7:0] rdata;
  logic [7:0] a_o;
  logic       a_oe;
  logic [7:0] a_i;
  logic       e_;
  logic       dir;

  modport master (
    output req, we, wdata, rdy, a_i,
    input  ack, err, rdata, a_o, a_oe, e_, dir
  );

  modport slave (
    input  req, we, wdata, rdy, a_i,
    output ack, err, rdata, a_o, a_oe, e_, dir
  );
endinterface

// File: rtl/sn74ls245_busctl.sv
// A-side sequencer for an sn74ls245 transceiver: req/ack transfers to e_/dir control with bus turnaround.
// Optional ACTIVE-phase timeout is built when XCVR_TIMEOUT_EN is defined.
module sn74ls245_busctl #(
  parameter int WR_CYC   = 2,
  parameter int RD_CYC   = 2,
  parameter int TURN_CYC = 1,
  parameter int TIMEOUT  = 16
) (
  input  logic             clk,
  input  logic             clr_,
  sn74ls245_busctl_if.slave bus
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_TURN   = 3'd1;
  localparam logic [2:0] S_SETUP  = 3'd2;
  localparam logic [2:0] S_ACTIVE = 3'd3;
  localparam logic [2:0] S_HOLD   = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  localparam int MAX_A   = (WR_CYC > RD_CYC) ? WR_CYC : RD_CYC;
  localparam int MAX_B   = (MAX_A > TURN_CYC) ? MAX_A : TURN_CYC;
  localparam int CNT_MAX = (MAX_B > TIMEOUT) ? MAX_B : TIMEOUT;
  localparam int CW      = $clog2(CNT_MAX + 1) + 1;

  localparam logic [CW-1:0] WR_MIN   = CW'(WR_CYC);
  localparam logic [CW-1:0] RD_MIN   = CW'(RD_CYC);
  localparam logic [CW-1:0] TURN_MIN = CW'(TURN_CYC);
  localparam logic [CW-1:0] CNT_SAT  = CW'(CNT_MAX);

  logic [2:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic          r_we;
  logic [7:0]    r_wdata;
  logic          r_dir;
  logic [7:0]    r_rdata;
  logic          r_err;

  logic [CW-1:0] w_min;
  logic          w_done;
  logic          w_tmo;

  // r_cnt holds the number of the current cycle within TURN/ACTIVE (first cycle = 1).
  assign w_min  = r_we ? WR_MIN : RD_MIN;
  assign w_done = (r_cnt >= w_min) && bus.rdy;

`ifdef XCVR_TIMEOUT_EN
  assign w_tmo = !w_done && (r_cnt >= CW'(TIMEOUT));
`else
  assign w_tmo = 1'b0;
`endif

  always_ff @(posedge clk or negedge clr_) begin
    if (!clr_) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_we    <= 1'b0;
      r_wdata <= 8'h00;
      r_dir   <= 1'b0;
      r_rdata <= 8'h00;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_cnt <= CW'(1);
          if (bus.req) begin
            r_we    <= bus.we;
            r_wdata <= bus.wdata;
            r_err   <= 1'b0;
            // dir only ever moves here, while e_ is high, and always through TURN.
            if (bus.we != r_dir) begin
              r_dir   <= bus.we;
              r_state <= S_TURN;
            end else begin
              r_state <= S_SETUP;
            end
          end
        end
        S_TURN: begin
          if (r_cnt >= TURN_MIN) begin
            r_state <= S_SETUP;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_SETUP: begin
          r_cnt   <= CW'(1);
          r_state <= S_ACTIVE;
        end
        S_ACTIVE: begin
          if (w_done) begin
            if (!r_we) begin
              r_rdata <= bus.a_i;
            end
            r_state <= S_HOLD;
          end else if (w_tmo) begin
            r_err   <= 1'b1;
            r_state <= S_HOLD;
          end else if (r_cnt != CNT_SAT) begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_HOLD: begin
          r_state <= S_DONE;
        end
        S_DONE: begin
          r_cnt   <= '0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Write data is presented one cycle before e_ falls and held one cycle after it rises.
  assign bus.a_oe  = r_we && ((r_state == S_SETUP) || (r_state == S_ACTIVE) || (r_state == S_HOLD));
  assign bus.a_o   = r_wdata;
  assign bus.e_    = (r_state != S_ACTIVE);
  assign bus.dir   = r_dir;
  assign bus.ack   = (r_state == S_DONE);
  assign bus.err   = r_err;
  assign bus.rdata = r_rdata;

endmodule
